// File: rtl/clock_divider_bank.sv
// Bank of NCH independent programmable clock dividers.
// Each channel runs a counter over 0..Deff-1 and drives a registered divided
// clock plus a one-cycle end-of-period tick. New ratios/enables for a running
// channel are staged in a per-channel pending slot and take effect only at the
// channel's wrap. This keeps every output pulse at its full width.
//
// Configuration handshake: a request transfers on a clk_in rising edge where
// cfg_valid=1 and cfg_ready=1. cfg_ready is combinational on cfg_chan and is
// low only while the addressed channel already holds a pending update. It is
// forced high during reset, and requests seen while rst=1 are dropped.
// Requests to a channel index >= NCH are accepted and discarded.
module clock_divider_bank #(
  parameter int NCH         = 4,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2,
  localparam int CW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CW-1:0]    cfg_chan,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_en,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick,
  output logic             busy
);

  // Ratios 0 and 1 cannot produce a clock, so they run as divide-by-2.
  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
    return (d < DIV_W'(2)) ? DIV_W'(2) : d;
  endfunction

  // Active configuration, counter and pending slot per channel.
  logic [DIV_W-1:0] act_div  [NCH];
  logic [DIV_W-1:0] cnt      [NCH];
  logic [DIV_W-1:0] pend_div [NCH];
  logic [NCH-1:0]   act_en;
  logic [NCH-1:0]   pend_en;
  logic [NCH-1:0]   pend;
  logic [NCH-1:0]   clk_q;
  logic [NCH-1:0]   tick_q;

  // Next-state values.
  logic [DIV_W-1:0] deff      [NCH];
  logic [DIV_W-1:0] n_div     [NCH];
  logic [DIV_W-1:0] n_cnt     [NCH];
  logic [DIV_W-1:0] n_pdiv    [NCH];
  logic [DIV_W-1:0] n_deff    [NCH];
  logic [NCH-1:0]   n_en;
  logic [NCH-1:0]   n_pen;
  logic [NCH-1:0]   n_pend;
  logic [NCH-1:0]   n_clk;
  logic [NCH-1:0]   n_tick;
  logic [NCH-1:0]   wrap;
  logic [NCH-1:0]   acc;

  // Ready reflects only the addressed channel's pending flag.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_chan == CW'(i)) cfg_ready = ~pend[i];
    end
    if (rst) cfg_ready = 1'b1;
  end

  assign busy    = |pend;
  assign clk_out = clk_q;
  assign tick    = tick_q;

  // Per-channel next state: count, wrap, pending promotion and request capture.
  // Outputs are derived from the next counter value so that the registered
  // clk_out and tick line up with the counter they describe.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      deff[i]   = eff_div(act_div[i]);
      wrap[i]   = act_en[i] && (cnt[i] == deff[i] - DIV_W'(1));
      acc[i]    = cfg_valid && cfg_ready && !rst && (cfg_chan == CW'(i));
      n_div[i]  = act_div[i];
      n_en[i]   = act_en[i];
      n_cnt[i]  = cnt[i] + DIV_W'(1);
      n_pdiv[i] = pend_div[i];
      n_pen[i]  = pend_en[i];
      n_pend[i] = pend[i];
      if (!act_en[i]) begin
        // Idle channel: take the request directly, counter restarts at 0.
        n_cnt[i] = '0;
        if (acc[i]) begin
          n_div[i] = cfg_div;
          n_en[i]  = cfg_en;
        end
      end else begin
        if (wrap[i]) begin
          n_cnt[i] = '0;
          if (pend[i]) begin
            n_div[i]  = pend_div[i];
            n_en[i]   = pend_en[i];
            n_pend[i] = 1'b0;
          end
        end
        // A request landing on the wrap cycle is staged for the next wrap.
        if (acc[i]) begin
          n_pdiv[i] = cfg_div;
          n_pen[i]  = cfg_en;
          n_pend[i] = 1'b1;
        end
      end
      n_deff[i] = eff_div(n_div[i]);
      n_clk[i]  = n_en[i] && (n_cnt[i] < (n_deff[i] >> 1));
      n_tick[i] = n_en[i] && (n_cnt[i] == n_deff[i] - DIV_W'(1));
    end
  end

  // State registers with synchronous reset that also drops pending updates.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        act_div[i]  <= DIV_W'(DEFAULT_DIV);
        cnt[i]      <= '0;
        pend_div[i] <= '0;
      end
      act_en  <= '0;
      pend_en <= '0;
      pend    <= '0;
      clk_q   <= '0;
      tick_q  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        act_div[i]  <= n_div[i];
        cnt[i]      <= n_cnt[i];
        pend_div[i] <= n_pdiv[i];
      end
      act_en  <= n_en;
      pend_en <= n_pen;
      pend    <= n_pend;
      clk_q   <= n_clk;
      tick_q  <= n_tick;
    end
  end

endmodule

// File: doc/clock_divider_bank.md
CLOCK_DIVIDER_BANK -- requirements
Module: clock_divider_bank

Interface
REQ-001 Parameter NCH, default 4, number of independent divided-clock channels (1..16).
REQ-002 Parameter DIV_W, default 8, width of each channel's divide ratio.
REQ-003 Parameter DEFAULT_DIV, default 2, divide ratio loaded into every channel at reset.
REQ-004 Port clk_in  input  1  sole clock; all logic on rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port cfg_valid  input  1  configuration request strobe.
REQ-007 Port cfg_ready  output  1  configuration accepted when high with cfg_valid.
REQ-008 Port cfg_chan  input  clog2(NCH) (min 1)  target channel index.
REQ-009 Port cfg_div  input  DIV_W  requested divide ratio D.
REQ-010 Port cfg_en  input  1  requested channel enable.
REQ-011 Port clk_out  output  NCH  registered divided clocks, one bit per channel.
REQ-012 Port tick  output  NCH  one-cycle pulse per channel at the end of each output period.
REQ-013 Port busy  output  1  high while any channel holds a pending configuration.

Function
REQ-014 Each channel SHALL hold an active ratio, an active enable, a counter cnt (DIV_W bits) and a pending slot (ratio, enable, pending flag).
REQ-015 Effective ratio Deff SHALL be max(D, 2); D values 0 and 1 are clamped to 2.
REQ-016 Enabled channel: cnt SHALL count 0..Deff-1, then wrap to 0.
REQ-017 clk_out[i] SHALL be a register, high during cycles where cnt < floor(Deff/2), otherwise low; Deff=2 gives 50% duty, odd Deff gives a shorter high phase (D=3: 1 high, 2 low).
REQ-018 tick[i] SHALL be high for exactly the one cycle in which cnt == Deff-1 while the channel is enabled.
REQ-019 Disabled channel: cnt held 0, clk_out[i] = 0, tick[i] = 0.
REQ-020 Handshake: transfer occurs on a cycle with cfg_valid=1 and cfg_ready=1; cfg_ready SHALL equal NOT pending[cfg_chan] (combinational on cfg_chan); cfg_chan >= NCH SHALL give cfg_ready=1 and the request SHALL be discarded.
REQ-021 Accepted request to an enabled channel SHALL write the pending slot; it becomes active on the wrap cycle (cnt == Deff-1), with cnt restarting at 0 under the new ratio/enable; no clk_out pulse SHALL be truncated or stretched.
REQ-022 Accepted request to a disabled channel SHALL become active on the next cycle (no pending state); if cfg_en=1, cnt starts at 0 and clk_out rises one cycle after acceptance.
REQ-023 Acceptance coinciding with the wrap cycle of an enabled channel SHALL apply at the next wrap, not the current one.
REQ-024 Disable via pending slot: at the wrap, channel enters disabled state; clk_out already low, so no glitch.
REQ-025 busy SHALL be the OR of all pending flags; channels SHALL operate fully independently.
REQ-026 Only one request per cycle; latency from acceptance to effect is bounded by Deff_old cycles.

Reset
REQ-027 While rst=1 at a clock edge: all cnt = 0, all clk_out = 0, all tick = 0, all active enables = 0, all active ratios = DEFAULT_DIV, all pending flags = 0, busy = 0.
REQ-028 cfg_ready SHALL be 1 during and after reset (no pending state); requests during rst=1 SHALL be ignored.
REQ-029 Reset asserted mid-period SHALL discard pending configurations and drive clk_out low on the next edge.

Verification
REQ-030 Reset, then enable ch0 D=4 -> clk_out[0] high 2/low 2 repeating, first rise one cycle after acceptance, tick[0] every 4th cycle.
REQ-031 Ch1 running D=3, request D=6 mid-period -> old 1-high/2-low period completes, new 3-high/3-low starts at wrap; cfg_ready low and busy high until wrap.
REQ-032 Request D=0 and D=1 on ch2 -> behaves as D=2 (toggle every cycle, tick every 2nd cycle).
REQ-033 Ch0 D=8 running, request cfg_en=0 at cnt=1 -> clk_out[0] stays high until cnt=4, low thereafter, no further ticks.
REQ-034 Second request to ch1 while pending -> cfg_ready=0, not accepted; request to ch3 same cycle-window accepted immediately.
REQ-035 rst pulsed for one cycle with two channels running and one pending -> all outputs 0, busy 0, ratios back to DEFAULT_DIV, channels disabled.
